// File: rtl/instr_fetch.sv
// Mini TPU instruction front-end: pairs bytes into 16-bit words, queues them, issues one per cycle.
// Optional FETCH_FLUSH_EN adds a synchronous flush input that clears all queued state.
module instr_fetch #(
  parameter int DEPTH      = 4,
  parameter int RUN_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [15:0]            instruction,
  output logic                   instr_valid,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef FETCH_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = (RUN_CYCLES < 1) ? 1 : $clog2(RUN_CYCLES + 1);
  localparam logic [15:0] STOP_WORD = 16'h4000;

  logic          phase_q, phase_d;
  logic [7:0]    hi_byte_q, hi_byte_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic [15:0]   instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic [15:0]   mem_q [DEPTH];
  logic          flush_i;
  logic          accept, push, pop;
  logic [15:0]   head;

`ifdef FETCH_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    // Only registered state feeds byte_ready, so a same-cycle pop never frees a slot for the low byte.
    byte_ready    = !(phase_q && (count_q == (AW + 1)'(DEPTH)));
    accept        = byte_valid && byte_ready && !flush_i;
    push          = accept && phase_q;
    pop           = (count_q != '0) && (busy_cnt_q == '0) && !flush_i;

    phase_d       = phase_q;
    hi_byte_d     = hi_byte_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    busy_cnt_d    = busy_cnt_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;

    if (accept) begin
      phase_d = !phase_q;
      if (!phase_q) hi_byte_d = byte_in;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      instr_d       = head;
      instr_valid_d = 1'b1;
      busy_cnt_d    = (head[15:14] == 2'b00) ? CW'(RUN_CYCLES) : '0;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      phase_d       = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      busy_cnt_d    = '0;
      instr_d       = STOP_WORD;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= 1'b0;
      hi_byte_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      busy_cnt_q    <= '0;
      instr_q       <= STOP_WORD;
      instr_valid_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      hi_byte_q     <= hi_byte_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      busy_cnt_q    <= busy_cnt_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Storage is deliberately left unreset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {hi_byte_q, byte_in};
  end

  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = (busy_cnt_q != '0);
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch against a queue-based cycle model.
module tb_instr_fetch;
  localparam int DEPTH      = 4;
  localparam int RUN_CYCLES = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [7:0]             byte_in = '0;
  logic                   byte_valid = 1'b0;
  logic                   byte_ready;
  logic [15:0]            instruction;
  logic                   instr_valid;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef FETCH_FLUSH_EN
  logic                   flush = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [15:0] m_fq[$];
  bit          m_phase;
  logic [7:0]  m_hi;
  int          m_busy;
  logic [15:0] m_instr;
  bit          m_valid;

  instr_fetch #(.DEPTH(DEPTH), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .busy       (busy),
    .fifo_count (fifo_count)
`ifdef FETCH_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fq.delete();
    exp_q.delete();
    m_phase = 1'b0;
    m_busy  = 0;
    m_instr = 16'h4000;
    m_valid = 1'b0;
  endtask

  task automatic check_state();
    chk("fifo_count", 32'(fifo_count), m_fq.size());
    chk("busy", 32'(busy), 32'(m_busy != 0));
    chk("byte_ready", 32'(byte_ready), 32'(!(m_phase && m_fq.size() == DEPTH)));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instruction", 32'(instruction), 32'(m_instr));
  endtask

  // Called at a falling edge: check the state after the last rising edge, drive inputs,
  // advance the model across the next rising edge, then wait for the next falling edge.
  task automatic step(input bit bv, input logic [7:0] b, input bit fl, output bit acc);
    bit rdy;
    check_state();
    byte_valid = bv;
    byte_in    = b;
`ifdef FETCH_FLUSH_EN
    flush      = fl;
`endif
    rdy = !(m_phase && m_fq.size() == DEPTH);
    acc = 1'b0;
    if (fl) begin
      m_fq.delete();
      exp_q.delete();
      m_phase = 1'b0;
      m_busy  = 0;
      m_instr = 16'h4000;
      m_valid = 1'b0;
    end else begin
      if (m_fq.size() > 0 && m_busy == 0) begin
        m_instr = m_fq.pop_front();
        m_valid = 1'b1;
        m_busy  = (m_instr[15:14] == 2'b00) ? RUN_CYCLES : 0;
      end else begin
        m_valid = 1'b0;
        if (m_busy > 0) m_busy--;
      end
      if (bv && rdy) begin
        acc = 1'b1;
        if (!m_phase) m_hi = b;
        else begin
          m_fq.push_back({m_hi, b});
          exp_q.push_back({m_hi, b});
        end
        m_phase = !m_phase;
      end
    end
    @(negedge clk);
`ifdef FETCH_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, acc);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    idle(gap);
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) step(1'b1, b, 1'b0, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte %0h never accepted", b);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    logic [15:0] tmp;
    tmp = w;
    send_byte(tmp[15:8], gap);
    send_byte(tmp[7:0], gap);
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    model_reset();
    check_state();
    @(negedge clk);
    check_state();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (m_fq.size() == 0 && m_busy == 0 && !m_valid) break;
      idle(1);
    end
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every issued instruction must be the oldest outstanding word.
  always @(posedge clk) begin
    logic [15:0] w;
    #1;
    if (rst_n && instr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no issue", instruction);
      end else begin
        w = exp_q.pop_front();
        chk("sb_order", 32'(instruction), 32'(w));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit acc;
    logic [15:0] w;
    model_reset();
    @(negedge clk);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Single load
    send_word(16'h9105, 0);
    idle(1);
    chk("single_load_valid", 32'(instr_valid), 1);
    chk("single_load_word", 32'(instruction), 32'h9105);
    drain();

    // START stall followed by STORE
    send_word(16'h0000, 0);
    send_word(16'hC600, 0);
    drain();
    chk("start_then_store", 32'(instruction), 32'hC600);

    // Full FIFO behind a START, fifth word waits for the first pop
    send_word(16'h0000, 0);
    for (int i = 0; i < 4; i++) send_word(16'h8100 + 16'(i), 0);
    send_word(16'hA233, 0);
    drain();
    chk("full_fifo_last", 32'(instruction), 32'hA233);

    // Wrap-around with back-to-back LOADs
    for (int i = 0; i < 10; i++) send_word(16'h8000 + 16'(i), $urandom_range(0, 2));
    drain();
    chk("wrap_last", 32'(instruction), 32'h8009);

    // Reset between the two bytes of a pair
    step(1'b1, 8'h80, 1'b0, acc);
    do_reset();
    send_word(16'hB307, 0);
    drain();
    chk("reset_pair_word", 32'(instruction), 32'hB307);

`ifdef FETCH_FLUSH_EN
    send_word(16'h0000, 0);
    for (int i = 0; i < 3; i++) send_word(16'hC000 + 16'(i), 0);
    step(1'b1, 8'h55, 1'b1, acc);
    check_state();
    idle(12);
    send_word(16'h9A01, 0);
    drain();
`endif

    // Randomised traffic with occasional STARTs
    for (int i = 0; i < 60; i++) begin
      w = {(($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom_range(1, 3))), 14'($urandom)};
      send_word(w, $urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) begin
        step(1'b1, 8'($urandom), 1'b0, acc);
        do_reset();
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
